word_mem_sequencer: RTL and testbench
=====================================

# word_mem_sequencer

Sequencer that sits between the processor's memory stage and the byte-wide (8-bit) data memory. It accepts one 32-bit load or store request at a time and performs it as four consecutive big-endian byte accesses. It returns the assembled load word, or a store completion, over a valid/ready response handshake. Memory is synchronous: write on the clock edge, read data valid one cycle after the address.

## Interface
- ADDR_W, 7, byte address width (128-byte data memory)
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address of MSB; any alignment
- req_wdata  in  32  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  load word; 0 for store responses
- mem_addr  out  ADDR_W  byte address to memory, registered
- mem_we  out  1  byte write enable, registered
- mem_wdata  out  8  byte write data, registered
- mem_rdata  in  8  byte read data; valid the cycle after mem_addr

## Operation
- States: IDLE, XFER, DRAIN, RESP. Reset state is IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_we=0, mem_wdata=0, byte index k=0.
- IDLE: req_ready=1. On the edge where req_valid&req_ready is high (E0), capture write, addr and wdata, then go to XFER with k=0. Later changes on the req_* inputs are ignored.
- XFER: drive one byte per cycle for k=0..3.
  - mem_addr = (addr+k) mod 2^ADDR_W, so addresses wrap.
  - mem_we = write.
  - mem_wdata = wdata[31-8k -: 8], so k=0 is the MSB.
- Store: after the k=3 cycle go to RESP, with mem_we=0.
- Load: after the k=3 cycle go to DRAIN, with mem_we=0. Read bytes are shifted in MSB-first on each edge after their address cycle.
- DRAIN: capture byte 3, then go to RESP.
- RESP: rsp_valid=1 and req_ready=0. rsp_rdata is held stable until the edge where rsp_valid&rsp_ready is high, then go to IDLE.
- Ordering: at most one request is outstanding. A new request can be accepted no earlier than the edge after the response handshake.
- Reset asserted mid-operation: all outputs take their reset values immediately. Bytes already written stay in memory. No response is produced.

## Timing
- Registered outputs change only on rising edges, or asynchronously on reset.
- Store accepted at E0: bytes are written at edges E1..E4. rsp_valid is high starting in the cycle after E4, so store latency is 5 cycles from acceptance to the response handshake opportunity.
- Load accepted at E0: addresses are driven in cycles C1..C4. Bytes are captured at E2..E5. rsp_valid is high starting in the cycle after E5, so load latency is 6 cycles.
- With rsp_ready held high, throughput is one store per 6 cycles and one load per 7 cycles.
- req_ready is combinational from the state (IDLE only) and has no dependence on req_valid.

## Structure
- Package word_mem_seq_pkg holds:
  - the state enum (IDLE, XFER, DRAIN, RESP);
  - BYTES_PER_WORD = 4;
  - the 2-bit byte-index type.
- A single module implements the block; no sub-module is needed.
- The byte-lane select, wdata[31-8k -: 8], is a local function in the package.

## Test plan
- Store 0xDEADBEEF to 0x10, rsp_ready=1 -> memory 0x10..0x13 = DE AD BE EF at E1..E4; rsp_valid in the cycle after E4; rsp_rdata=0.
- Load from 0x10 after the store above -> mem_addr 10,11,12,13 in C1..C4; mem_we=0; rsp_rdata=0xDEADBEEF with rsp_valid in the cycle after E5.
- Wrap: store 0x01234567 to 0x7E -> 0x7E=01, 0x7F=23, 0x00=45, 0x01=67. Load from 0x7E returns 0x01234567.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP while req_valid=1 -> rsp_valid and rsp_rdata stay stable, req_ready=0, no new request accepted. After the handshake, the pending request is accepted on the next IDLE edge.
- Reset mid-store: pull reset_n low after E2 of a store of 0xAABBCCDD to 0x20 -> only 0x20=AA and 0x21=BB are written, all outputs at reset values. After release, a load from 0x20 is accepted normally.
- Back-to-back: store then load with req_valid held and rsp_ready=1 -> second acceptance occurs exactly one edge after the first response handshake; no byte access overlaps.

Source files
------------

// File: rtl/word_mem_seq_pkg.sv
// Shared types and helpers for the byte-serial word memory sequencer.
package word_mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Big-endian lane select: index 0 is the most significant byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input byte_idx_t k);
    logic [7:0] lane;
    case (k)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      2'd3:    lane = word[7:0];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/word_mem_sequencer.sv
// Performs one 32-bit load/store as four big-endian byte accesses on a
// synchronous byte-wide memory, returning the result over a valid/ready response.
module word_mem_sequencer
  import word_mem_seq_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            r_state;
  state_e            w_next_state;
  byte_idx_t         r_k;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [23:0]       r_shift;
  logic              w_last_byte;

  assign req_ready   = (r_state == IDLE);
  assign w_last_byte = (r_k == LAST_BYTE_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = XFER;
        end else begin
          w_next_state = IDLE;
        end
      end
      XFER: begin
        if (w_last_byte) begin
          w_next_state = r_write ? RESP : DRAIN;
        end else begin
          w_next_state = XFER;
        end
      end
      DRAIN: w_next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture, byte sequencing and read-data assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k       <= 2'd0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_shift   <= 24'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
    end else begin
      rsp_valid <= (w_next_state == RESP);
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_k       <= 2'd0;
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_shift   <= 24'd0;
            mem_addr  <= req_addr;
            mem_we    <= req_write;
            mem_wdata <= byte_lane(req_wdata, 2'd0);
          end
        end
        XFER: begin
          // Byte k-1 arrives while byte k's address is on the bus.
          if (r_k != 2'd0) begin
            r_shift <= {r_shift[15:0], mem_rdata};
          end
          if (w_last_byte) begin
            mem_we <= 1'b0;
            if (r_write) begin
              rsp_rdata <= 32'd0;
            end
          end else begin
            r_k       <= r_k + 2'd1;
            mem_addr  <= r_addr + ADDR_W'(r_k) + ADDR_W'(1);
            mem_we    <= r_write;
            mem_wdata <= byte_lane(r_wdata, r_k + 2'd1);
          end
        end
        DRAIN: begin
          rsp_rdata <= {r_shift, mem_rdata};
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_mem_sequencer.sv
// Scoreboard bench for word_mem_sequencer: directed scenarios plus random traffic
// checked against a word-level reference memory.
module tb_word_mem_sequencer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
    int          e0;
    logic [31:0] exp;
  } txn_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  tbmem [128];
  logic [7:0]  ref_mem [128];
  logic [31:0] fill_seed;
  logic        mem_init;
  txn_t        sb_q [$];
  logic        act_valid;
  int          act_e0;
  logic [6:0]  act_addr;
  logic        act_write;
  logic [31:0] act_wdata;
  logic        in_resp;
  logic [31:0] held;
  logic [31:0] last_rdata;
  int          last_hs;
  int          acc_cnt;
  logic        rand_ready_en;
  logic        rnd_ready;
  logic        fix_ready;

  assign rsp_ready = rand_ready_en ? rnd_ready : fix_ready;

  word_mem_sequencer #(.ADDR_W(7)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fill_byte(input int i);
    return 8'((i * 29 + int'(fill_seed)) & 255);
  endfunction

  // Synchronous byte memory: write on the edge, read data one cycle later.
  always @(posedge clk) begin
    mem_rdata <= tbmem[mem_addr];
    if (mem_init) begin
      for (int i = 0; i < 128; i++) tbmem[i] <= fill_byte(i);
    end else if (mem_we) begin
      tbmem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: byte-access window checks, response scoreboard, acceptance tracking.
  initial begin
    int          k;
    logic [31:0] e;
    txn_t        t;
    fill_seed  = $urandom;
    for (int i = 0; i < 128; i++) ref_mem[i] = fill_byte(i);
    act_valid  = 1'b0;
    in_resp    = 1'b0;
    last_hs    = -100;
    acc_cnt    = 0;
    last_rdata = 32'd0;
    held       = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        act_valid = 1'b0;
        in_resp   = 1'b0;
        sb_q.delete();
      end else begin
        k = act_valid ? (cyc - act_e0) : -1;
        if (k >= 0 && k <= 3) begin
          chk("mem_addr", 32'(mem_addr), 32'((int'(act_addr) + k) % 128));
          chk("mem_we", 32'(mem_we), 32'(act_write));
          if (act_write) begin
            chk("mem_wdata", 32'(mem_wdata), (act_wdata >> (8 * (3 - k))) & 32'hFF);
            ref_mem[(int'(act_addr) + k) % 128] = 8'(act_wdata >> (8 * (3 - k)));
          end
        end else begin
          chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
        if (rsp_valid) begin
          if (!in_resp) begin
            if (sb_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL spurious_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
              t = sb_q.pop_front();
              chk("rsp_rdata", rsp_rdata, t.exp);
              chk("rsp_latency", 32'(cyc), 32'(t.e0 + (t.w ? 4 : 5)));
              last_rdata = rsp_rdata;
              held       = rsp_rdata;
              in_resp    = 1'b1;
            end
          end else begin
            chk("rsp_hold", rsp_rdata, held);
          end
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (rsp_ready && in_resp) begin
            in_resp   = 1'b0;
            act_valid = 1'b0;
            last_hs   = cyc + 1;
          end
        end
        if (req_valid && req_ready) begin
          e = 32'd0;
          if (!req_write) begin
            for (int j = 0; j < 4; j++) e = (e << 8) | 32'(ref_mem[(int'(req_addr) + j) % 128]);
          end
          t.w = req_write; t.a = req_addr; t.d = req_wdata; t.e0 = cyc + 1; t.exp = e;
          sb_q.push_back(t);
          act_valid = 1'b1;
          act_e0    = cyc + 1;
          act_addr  = req_addr;
          act_write = req_write;
          act_wdata = req_wdata;
          acc_cnt++;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d,
                       input bit hold, output int e0);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 7'($urandom_range(0, 127));
      req_wdata = $urandom;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && !in_resp && req_ready;
    end
    chk("idle_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int          e0;
    int          saved;
    int          sel;
    logic [6:0]  a;
    reset_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
    rand_ready_en = 1'b0; fix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mem_init = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // Store then load at 0x10.
    issue(1'b1, 7'h10, 32'hDEADBEEF, 1'b0, e0);
    wait_idle();
    chk("st_mem10", 32'(tbmem[7'h10]), 32'hDE);
    chk("st_mem11", 32'(tbmem[7'h11]), 32'hAD);
    chk("st_mem12", 32'(tbmem[7'h12]), 32'hBE);
    chk("st_mem13", 32'(tbmem[7'h13]), 32'hEF);
    chk("st_rdata", last_rdata, 32'd0);
    issue(1'b0, 7'h10, 32'h0, 1'b0, e0);
    wait_idle();
    chk("ld_10", last_rdata, 32'hDEADBEEF);

    // Address wrap.
    issue(1'b1, 7'h7E, 32'h01234567, 1'b0, e0);
    wait_idle();
    chk("wrap_7e", 32'(tbmem[7'h7E]), 32'h01);
    chk("wrap_7f", 32'(tbmem[7'h7F]), 32'h23);
    chk("wrap_00", 32'(tbmem[7'h00]), 32'h45);
    chk("wrap_01", 32'(tbmem[7'h01]), 32'h67);
    issue(1'b0, 7'h7E, 32'h0, 1'b0, e0);
    wait_idle();
    chk("ld_wrap", last_rdata, 32'h01234567);

    // Backpressure with a pending request held on the bus.
    fix_ready = 1'b0;
    issue(1'b0, 7'h10, 32'h0, 1'b1, e0);
    req_write = 1'b1; req_addr = 7'h40; req_wdata = 32'hCAFEF00D;
    saved = acc_cnt;
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 fix_ready = 1'b1;
    chk("bp_no_accept", 32'(acc_cnt), 32'(saved));
    issue(1'b1, 7'h40, 32'hCAFEF00D, 1'b0, e0);
    chk("bp_accept_edge", 32'(e0), 32'(last_hs + 1));
    wait_idle();
    chk("bp_ld_data", 32'(tbmem[7'h40]), 32'hCA);

    // Reset during a store after its second byte has been written.
    issue(1'b1, 7'h20, 32'hAABBCCDD, 1'b0, e0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_20", 32'(tbmem[7'h20]), 32'hAA);
    chk("midrst_21", 32'(tbmem[7'h21]), 32'hBB);
    chk("midrst_22", 32'(tbmem[7'h22]), 32'(ref_mem[7'h22]));
    chk("midrst_23", 32'(tbmem[7'h23]), 32'(ref_mem[7'h23]));
    issue(1'b0, 7'h20, 32'h0, 1'b0, e0);
    wait_idle();
    chk("midrst_ld_hi", last_rdata >> 16, 32'hAABB);

    // Back-to-back store then load with req_valid held.
    issue(1'b1, 7'h30, 32'h13579BDF, 1'b1, e0);
    req_write = 1'b0; req_addr = 7'h30; req_wdata = 32'h0;
    issue(1'b0, 7'h30, 32'h0, 1'b0, e0);
    chk("b2b_accept_edge", 32'(e0), 32'(last_hs + 1));
    wait_idle();
    chk("b2b_ld", last_rdata, 32'h13579BDF);

    // Random traffic with random response backpressure.
    rand_ready_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0)      a = 7'(8'h10 + $urandom_range(0, 7));
      else if (sel == 1) a = 7'(8'h7C + $urandom_range(0, 3));
      else               a = 7'($urandom_range(0, 127));
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b0, e0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    rand_ready_en = 1'b0;
    for (int i = 0; i < 128; i++) chk("final_mem", 32'(tbmem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
